// File: rtl/alu_pkg.sv
// Shared ALU definitions. The ALU control decoder and the execute-stage ALU both use these codes.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// done/product are combinational so the caller can register the final sum on the last step's edge.
module alu_mul_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned STEPS = WIDTH / MUL_STEP;
    localparam int unsigned CW    = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] partial;
    logic [CW-1:0]    count;
    logic             busy;

    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    assign product = acc + partial;
    assign done    = busy && (count == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
            count  <= count + 1'b1;
            if (abort || done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle ops register in one cycle, mul iterates in alu_mul_iter.
// valid/ready handshake on both sides; flush kills whatever is held or in flight.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_t       state;
    alu_state_t       state_next;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;

    assign shamt     = data2_i[SHW-1:0];
    assign is_mul    = (ctrl_i == ALU_MUL);
    assign accept    = valid_i && ready_o;
    assign mul_start = accept && is_mul;

    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            ALU_AND:  alu_res = data1_i & data2_i;
            ALU_XOR:  alu_res = data1_i ^ data2_i;
            ALU_SLL:  alu_res = data1_i << shamt;
            ALU_ADD:  alu_res = data1_i + data2_i;
            ALU_SUB:  alu_res = data1_i - data2_i;
            ALU_ADDI: alu_res = data1_i + data2_i;
            ALU_SRAI: alu_res = $signed(data1_i) >>> shamt;
            default:  alu_res = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .start   (mul_start),
        .abort   (flush_i),
        .op_a    (data1_i),
        .op_b    (data2_i),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_next = is_mul ? ST_MUL : ST_DONE;
                    end else if (state == ST_DONE && ready_i) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_next = ST_DONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state)
            ST_IDLE: ready_o = !flush_i;
            ST_DONE: begin
                valid_o = 1'b1;
                ready_o = !flush_i && ready_i;
            end
            default: ;
        endcase
    end

    // A flush never writes the result; the mul completion is dropped with it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b0;
        end else if (accept && !is_mul) begin
            result_o <= alu_res;
            zero_o   <= (alu_res == '0);
        end else if (state == ST_MUL && mul_done && !flush_i) begin
            result_o <= mul_product;
            zero_o   <= (mul_product == '0);
        end
    end

endmodule
